// File: rtl/decode_prefix_sequencer.sv
// Prefix sequencer for the instruction decoder front end.
// Consumes instruction bytes from the prefetch queue, accumulates the legacy
// prefix state (operand/address size, lock, segment override, REP/REPNE) and
// presents the bundle together with the first non-prefix byte to the decoder.
// An instruction carrying more than MAX_PREFIX prefixes is terminated with
// out_error_o set and the overflowing prefix byte reported as the opcode.
//
// Ports
//   clock_i              rising-edge clock
//   reset_i              synchronous active-high reset
//   flush_i              drop the in-progress instruction
//   byte_valid_i/_data_i prefetch queue byte and its valid
//   byte_ready_o         byte accepted this cycle (COLLECT)
//   out_valid_o          bundle available (HOLD)
//   out_ready_i          decoder accepts the bundle
//   out_*_o              registered bundle fields
module decode_prefix_sequencer #(
    parameter int unsigned MAX_PREFIX = 14
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       flush_i,
    input  logic       byte_valid_i,
    input  logic [7:0] byte_data_i,
    output logic       byte_ready_o,
    output logic       out_valid_o,
    input  logic       out_ready_i,
    output logic [7:0] out_opcode_o,
    output logic       out_address_size_o,
    output logic       out_operand_size_o,
    output logic       out_bus_lock_o,
    output logic [2:0] out_segment_o,
    output logic [1:0] out_rep_o,
    output logic [3:0] out_prefix_count_o,
    output logic       out_error_o
);

    localparam int unsigned CNT_W = 4;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PREFIX);
    localparam logic [CNT_W-1:0] CNT_OVF = CNT_W'(MAX_PREFIX + 1);

    localparam logic [0:0] ST_COLLECT = 1'b0;
    localparam logic [0:0] ST_HOLD    = 1'b1;

    logic [0:0]       state_q, state_d;
    logic             byte_ready_q, byte_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       opcode_q, opcode_d;
    logic             asz_q, asz_d;
    logic             osz_q, osz_d;
    logic             lock_q, lock_d;
    logic [2:0]       seg_q, seg_d;
    logic [1:0]       rep_q, rep_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             error_q, error_d;

    logic       is_prefix;
    logic       is_seg;
    logic [2:0] seg_code;
    logic       is_rep;
    logic [1:0] rep_code;
    logic       is_osz;
    logic       is_asz;
    logic       is_lock;

    logic byte_fire;
    logic out_fire;

    // byte_ready_q is only ever high in COLLECT, so it doubles as the state qualifier.
    assign byte_fire = byte_valid_i & byte_ready_q;
    assign out_fire  = out_valid_q & out_ready_i;

    // Prefix byte classification.
    always_comb begin
        is_prefix = 1'b1;
        is_seg    = 1'b0;
        seg_code  = 3'd0;
        is_rep    = 1'b0;
        rep_code  = 2'b00;
        is_osz    = 1'b0;
        is_asz    = 1'b0;
        is_lock   = 1'b0;
        case (byte_data_i)
            8'h26: begin is_seg = 1'b1; seg_code = 3'd1; end
            8'h2E: begin is_seg = 1'b1; seg_code = 3'd2; end
            8'h36: begin is_seg = 1'b1; seg_code = 3'd3; end
            8'h3E: begin is_seg = 1'b1; seg_code = 3'd4; end
            8'h64: begin is_seg = 1'b1; seg_code = 3'd5; end
            8'h65: begin is_seg = 1'b1; seg_code = 3'd6; end
            8'h66: is_osz  = 1'b1;
            8'h67: is_asz  = 1'b1;
            8'hF0: is_lock = 1'b1;
            8'hF2: begin is_rep = 1'b1; rep_code = 2'b10; end
            8'hF3: begin is_rep = 1'b1; rep_code = 2'b11; end
            default: is_prefix = 1'b0;
        endcase
    end

    // Next-state and bundle update.
    always_comb begin
        state_d  = state_q;
        opcode_d = opcode_q;
        asz_d    = asz_q;
        osz_d    = osz_q;
        lock_d   = lock_q;
        seg_d    = seg_q;
        rep_d    = rep_q;
        count_d  = count_q;
        error_d  = error_q;

        if (flush_i) begin
            state_d  = ST_COLLECT;
            opcode_d = 8'h00;
            asz_d    = 1'b0;
            osz_d    = 1'b0;
            lock_d   = 1'b0;
            seg_d    = 3'd0;
            rep_d    = 2'b00;
            count_d  = '0;
            error_d  = 1'b0;
        end else begin
            case (state_q)
                ST_COLLECT: begin
                    if (byte_fire) begin
                        if (is_prefix && (count_q == CNT_MAX)) begin
                            // One prefix too many: terminate the instruction as an error.
                            opcode_d = byte_data_i;
                            error_d  = 1'b1;
                            count_d  = CNT_OVF;
                            state_d  = ST_HOLD;
                        end else if (is_prefix) begin
                            count_d = count_q + CNT_W'(1);
                            if (is_seg)  seg_d  = seg_code;
                            if (is_rep)  rep_d  = rep_code;
                            if (is_osz)  osz_d  = 1'b1;
                            if (is_asz)  asz_d  = 1'b1;
                            if (is_lock) lock_d = 1'b1;
                        end else begin
                            opcode_d = byte_data_i;
                            state_d  = ST_HOLD;
                        end
                    end
                end
                ST_HOLD: begin
                    if (out_fire) begin
                        state_d  = ST_COLLECT;
                        opcode_d = 8'h00;
                        asz_d    = 1'b0;
                        osz_d    = 1'b0;
                        lock_d   = 1'b0;
                        seg_d    = 3'd0;
                        rep_d    = 2'b00;
                        count_d  = '0;
                        error_d  = 1'b0;
                    end
                end
                default: state_d = ST_COLLECT;
            endcase
        end

        byte_ready_d = (state_d == ST_COLLECT);
        out_valid_d  = (state_d == ST_HOLD);
    end

    // State and output registers; reset overrides flush and both handshakes.
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= ST_COLLECT;
            byte_ready_q <= 1'b0;
            out_valid_q  <= 1'b0;
            opcode_q     <= 8'h00;
            asz_q        <= 1'b0;
            osz_q        <= 1'b0;
            lock_q       <= 1'b0;
            seg_q        <= 3'd0;
            rep_q        <= 2'b00;
            count_q      <= '0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            byte_ready_q <= byte_ready_d;
            out_valid_q  <= out_valid_d;
            opcode_q     <= opcode_d;
            asz_q        <= asz_d;
            osz_q        <= osz_d;
            lock_q       <= lock_d;
            seg_q        <= seg_d;
            rep_q        <= rep_d;
            count_q      <= count_d;
            error_q      <= error_d;
        end
    end

    assign byte_ready_o       = byte_ready_q;
    assign out_valid_o        = out_valid_q;
    assign out_opcode_o       = opcode_q;
    assign out_address_size_o = asz_q;
    assign out_operand_size_o = osz_q;
    assign out_bus_lock_o     = lock_q;
    assign out_segment_o      = seg_q;
    assign out_rep_o          = rep_q;
    assign out_prefix_count_o = count_q;
    assign out_error_o        = error_q;

endmodule

// File: tb/tb_decode_prefix_sequencer.sv
// Bench for decode_prefix_sequencer: directed scenarios plus randomized
// traffic, all checked against a model that decodes the list of bytes
// accepted for the current instruction.
module tb_decode_prefix_sequencer;

    localparam int unsigned MAX = 14;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       flush = 1'b0;
    logic       byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;
    logic       byte_ready;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_opcode;
    logic       out_address_size;
    logic       out_operand_size;
    logic       out_bus_lock;
    logic [2:0] out_segment;
    logic [1:0] out_rep;
    logic [3:0] out_prefix_count;
    logic       out_error;

    always #5 clk = ~clk;

    decode_prefix_sequencer #(.MAX_PREFIX(MAX)) dut (
        .clock_i            (clk),
        .reset_i            (reset),
        .flush_i            (flush),
        .byte_valid_i       (byte_valid),
        .byte_data_i        (byte_data),
        .byte_ready_o       (byte_ready),
        .out_valid_o        (out_valid),
        .out_ready_i        (out_ready),
        .out_opcode_o       (out_opcode),
        .out_address_size_o (out_address_size),
        .out_operand_size_o (out_operand_size),
        .out_bus_lock_o     (out_bus_lock),
        .out_segment_o      (out_segment),
        .out_rep_o          (out_rep),
        .out_prefix_count_o (out_prefix_count),
        .out_error_o        (out_error)
    );

    // {opcode, asz, osz, lock, segment, rep, count, error}
    logic [20:0] dut_f;
    assign dut_f = {out_opcode, out_address_size, out_operand_size, out_bus_lock,
                    out_segment, out_rep, out_prefix_count, out_error};

    int tests = 0;
    int fails = 0;

    logic [7:0] mq[$];
    bit         m_ready = 1'b0;
    bit         m_hold  = 1'b0;
    bit         armed   = 1'b0;

    logic [7:0] pfx_tab [11] = '{8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65,
                                 8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3};

    function automatic bit is_pfx(input logic [7:0] b);
        return b inside {8'h26, 8'h2E, 8'h36, 8'h3E, 8'h64, 8'h65,
                         8'h66, 8'h67, 8'hF0, 8'hF2, 8'hF3};
    endfunction

    // Bundle implied by the bytes accepted so far for one instruction.
    function automatic logic [20:0] decode(input logic [7:0] bq[$]);
        logic [7:0] op;
        bit a, o, l, e;
        logic [2:0] s;
        logic [1:0] r;
        int n;
        op = 8'h00; a = 0; o = 0; l = 0; e = 0; s = 3'd0; r = 2'b00; n = 0;
        foreach (bq[i]) begin
            if (!is_pfx(bq[i])) begin
                op = bq[i];
            end else if (n == int'(MAX)) begin
                op = bq[i];
                e  = 1;
                n  = int'(MAX) + 1;
            end else begin
                n++;
                case (bq[i])
                    8'h26: s = 3'd1;
                    8'h2E: s = 3'd2;
                    8'h36: s = 3'd3;
                    8'h3E: s = 3'd4;
                    8'h64: s = 3'd5;
                    8'h65: s = 3'd6;
                    8'h66: o = 1;
                    8'h67: a = 1;
                    8'hF0: l = 1;
                    8'hF2: r = 2'b10;
                    default: r = 2'b11;
                endcase
            end
        end
        return {op, a, o, l, s, r, 4'(n), e};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive inputs, advance the model, compare after the edge.
    task automatic step(input bit v, input logic [7:0] d, input bit ordy,
                        input bit fl, input bit rs);
        logic [20:0] f;
        @(negedge clk);
        byte_valid = v;
        byte_data  = d;
        out_ready  = ordy;
        flush      = fl;
        reset      = rs;
        @(posedge clk);
        if (rs) begin
            mq.delete();
            m_ready = 0;
            m_hold  = 0;
            armed   = 1;
        end else if (fl) begin
            mq.delete();
            m_hold  = 0;
            m_ready = 1;
        end else if (m_hold) begin
            if (ordy) begin
                mq.delete();
                m_hold  = 0;
                m_ready = 1;
            end
        end else begin
            if (v && m_ready) begin
                mq.push_back(d);
                f = decode(mq);
                if (f[0] || !is_pfx(d)) m_hold = 1;
            end
            m_ready = !m_hold;
        end
        #1;
        if (armed) begin
            check("byte_ready", 32'(byte_ready), 32'(m_ready));
            check("out_valid", 32'(out_valid), 32'(m_hold));
            if (m_hold || mq.size() == 0) begin
                f = decode(mq);
                check("fields", 32'(dut_f), 32'(f));
            end
        end
    endtask

    task automatic feed(input logic [7:0] b, input bit ordy);
        step(1, b, ordy, 0, 0);
    endtask

    initial begin
        logic [20:0] mf;
        int pct;

        // Reset state
        step(0, 8'h00, 0, 0, 1);
        step(0, 8'h00, 1, 1, 1);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(byte_ready), 32'd0);
        check("rst_fields", 32'(dut_f), 32'd0);
        step(0, 8'h00, 0, 0, 0);
        check("post_rst_ready", 32'(byte_ready), 32'd1);

        // Size, address, lock and CS override
        feed(8'h66, 1); feed(8'h67, 1); feed(8'hF0, 1); feed(8'h2E, 1); feed(8'h89, 1);
        check("t033_valid", 32'(out_valid), 32'd1);
        check("t033_opcode", 32'(out_opcode), 32'h89);
        check("t033_flags", 32'({out_operand_size, out_address_size, out_bus_lock}), 32'h7);
        check("t033_seg", 32'(out_segment), 32'd2);
        check("t033_cnt", 32'(out_prefix_count), 32'd4);
        check("t033_err", 32'(out_error), 32'd0);
        step(0, 8'h00, 1, 0, 0);

        // Last-wins segment and REP
        feed(8'h26, 0); feed(8'h64, 0); feed(8'hF2, 0); feed(8'hF3, 0); feed(8'hA5, 0);
        check("t034_seg", 32'(out_segment), 32'd5);
        check("t034_rep", 32'(out_rep), 32'd3);
        check("t034_cnt", 32'(out_prefix_count), 32'd4);
        check("t034_opcode", 32'(out_opcode), 32'hA5);
        mf = decode(mq);
        check("t034_model", 32'(mf), 32'({8'hA5, 3'b000, 3'd5, 2'b11, 4'd4, 1'b0}));
        step(0, 8'h00, 1, 0, 0);

        // Back-pressure in HOLD
        feed(8'h90, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, 8'($urandom), 0, 0, 0);
            check("t035_hold_opc", 32'(out_opcode), 32'h90);
            check("t035_hold_rdy", 32'(byte_ready), 32'd0);
        end
        step(0, 8'h00, 1, 0, 0);
        check("t035_rdy", 32'(byte_ready), 32'd1);
        check("t035_clr", 32'(dut_f), 32'd0);

        // Prefix overflow
        for (int i = 0; i < 15; i++) feed(8'h66, 0);
        check("t036_valid", 32'(out_valid), 32'd1);
        check("t036_err", 32'(out_error), 32'd1);
        check("t036_cnt", 32'(out_prefix_count), 32'd15);
        check("t036_opcode", 32'(out_opcode), 32'h66);
        step(0, 8'h00, 1, 0, 0);

        // Flush mid-instruction drops the concurrent byte
        feed(8'h3E, 1); feed(8'h66, 1);
        step(1, 8'h8B, 1, 1, 0);
        check("t037_flush_clr", 32'(dut_f), 32'd0);
        check("t037_flush_valid", 32'(out_valid), 32'd0);
        feed(8'h8B, 0);
        check("t037_seg", 32'(out_segment), 32'd0);
        check("t037_cnt", 32'(out_prefix_count), 32'd0);
        check("t037_opcode", 32'(out_opcode), 32'h8B);
        check("t037_valid", 32'(out_valid), 32'd1);

        // Reset in HOLD beats the handshake
        step(1, 8'hC3, 1, 0, 1);
        check("t038_valid", 32'(out_valid), 32'd0);
        check("t038_ready", 32'(byte_ready), 32'd0);
        check("t038_fields", 32'(dut_f), 32'd0);
        step(0, 8'h00, 0, 0, 0);

        // Randomized traffic; the second half is prefix-heavy to reach overflow
        for (int c = 0; c < 6000; c++) begin
            logic [7:0] b;
            pct = (c < 3000) ? 60 : 97;
            if ($urandom_range(0, 99) < pct) b = pfx_tab[$urandom_range(0, 10)];
            else b = 8'($urandom);
            step($urandom_range(0, 99) < 75, b,
                 $urandom_range(0, 99) < 50,
                 $urandom_range(0, 199) < 3,
                 $urandom_range(0, 399) < 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
